antitheft_ctrl_n: RTL and testbench

ANTITHEFT_CTRL_N -- requirements
Module: antitheft_ctrl_n

---
 rtl/antitheft_ctrl_n.sv | 126 ++++++++++++
 tb/tb_antitheft_ctrl_n.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/antitheft_ctrl_n.sv
// Vehicle anti-theft controller: entry delay, siren timeout with silent mode after
// repeated alarms, passive re-arm, and a fuel-pump immobiliser.
module antitheft_ctrl_n #(
  parameter int N_DOORS    = 4,
  parameter int TW         = 5,
  parameter int T_DRV      = 8,
  parameter int T_PASS     = 15,
  parameter int T_ALARM    = 10,
  parameter int T_ARM      = 6,
  parameter int MAX_ALARMS = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               one_hz_enable,
  input  logic               ignition,
  input  logic [N_DOORS-1:0] door,
  input  logic               hidden_switch,
  input  logic               brake,
  output logic               siren,
  output logic               status,
  output logic               fuel_pump,
  output logic [2:0]         state,
  output logic [TW-1:0]      remaining
);

  localparam int AW = (MAX_ALARMS < 1) ? 1 : $clog2(MAX_ALARMS + 1);

  if (N_DOORS < 1 || N_DOORS > 8) begin : g_bad_doors
    $error("antitheft_ctrl_n: N_DOORS out of range");
  end
  if (T_DRV < 1 || T_DRV >= (1 << TW) || T_PASS < 1 || T_PASS >= (1 << TW) ||
      T_ALARM < 1 || T_ALARM >= (1 << TW) || T_ARM < 1 || T_ARM >= (1 << TW)) begin : g_bad_delay
    $error("antitheft_ctrl_n: delay parameter does not fit timer");
  end

  typedef enum logic [2:0] {
    ARMED = 3'd0, TRIGGERED = 3'd1, ALARM = 3'd2, DISARMED = 3'd3,
    WAIT_OPEN = 3'd4, WAIT_CLOSE = 3'd5, ARM_DELAY = 3'd6
  } state_t;

  state_t        cur, nxt;
  logic [TW-1:0] count, load_val;
  logic [AW-1:0] alarm_cnt, alarm_nxt;
  logic          expired, any_door, timed;

  assign expired  = (count == '0);
  assign any_door = |door;
  assign timed    = (cur == TRIGGERED) || (cur == ALARM) || (cur == ARM_DELAY);

  always_comb begin
    nxt       = cur;
    load_val  = '0;
    alarm_nxt = alarm_cnt;
    case (cur)
      ARMED: begin
        if (ignition) nxt = DISARMED;
        else if (door[0]) begin
          nxt = TRIGGERED; load_val = TW'(T_DRV);
        end else if (any_door) begin
          nxt = TRIGGERED; load_val = TW'(T_PASS);
        end
      end
      TRIGGERED: begin
        if (ignition) nxt = DISARMED;
        else if (expired) begin
          nxt = ALARM; load_val = TW'(T_ALARM);
        end
      end
      ALARM: begin
        // Timeout beats ignition so a thief cannot cut the alarm short.
        if (expired) begin
          nxt = ARMED;
          if (alarm_cnt < AW'(MAX_ALARMS)) alarm_nxt = alarm_cnt + 1'b1;
        end else if (ignition) nxt = DISARMED;
      end
      DISARMED:  if (!ignition) nxt = WAIT_OPEN;
      WAIT_OPEN: begin
        if (ignition) nxt = DISARMED;
        else if (door[0]) nxt = WAIT_CLOSE;
      end
      WAIT_CLOSE: begin
        if (ignition) nxt = DISARMED;
        else if (!any_door) begin
          nxt = ARM_DELAY; load_val = TW'(T_ARM);
        end
      end
      ARM_DELAY: begin
        if (ignition) nxt = DISARMED;
        else if (any_door) nxt = WAIT_CLOSE;
        else if (expired) nxt = ARMED;
      end
      default: nxt = ARMED;
    endcase
    if (nxt == DISARMED) alarm_nxt = '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cur       <= ARMED;
      count     <= '0;
      alarm_cnt <= '0;
      status    <= 1'b0;
      siren     <= 1'b0;
      fuel_pump <= 1'b0;
    end else begin
      cur       <= nxt;
      alarm_cnt <= alarm_nxt;
      // Any state change reloads the timer; untimed states load 0.
      if (nxt != cur) count <= load_val;
      else if (timed && one_hz_enable && !expired) count <= count - 1'b1;

      if (nxt == TRIGGERED || nxt == ALARM) status <= 1'b1;
      else if (nxt == ARMED && cur == ARMED) status <= status ^ one_hz_enable;
      else status <= 1'b0;

      siren <= (nxt == ALARM) && (alarm_nxt < AW'(MAX_ALARMS));

      if (nxt != DISARMED || !ignition) fuel_pump <= 1'b0;
      else if (cur == DISARMED && hidden_switch && brake) fuel_pump <= 1'b1;
    end
  end

  assign state     = cur;
  assign remaining = count;

endmodule

// File: tb/tb_antitheft_ctrl_n.sv
// Directed bench for antitheft_ctrl_n: expected outputs are queued with each step
// and popped for comparison once the clock edge has been taken.
module tb_antitheft_ctrl_n;
  logic       clock = 0, reset = 1, one_hz_enable = 0, ignition = 0;
  logic [3:0] door = '0;
  logic       hidden_switch = 0, brake = 0;
  logic       siren, status, fuel_pump;
  logic [2:0] state;
  logic [4:0] remaining;

  int checks = 0, failures = 0;

  typedef struct {
    string tag;
    int    st, rem, sir, sts, fp;  // -1 means don't care
  } exp_t;
  exp_t exp_q[$];

  localparam int ARMED = 0, TRIG = 1, ALRM = 2, DISA = 3, WOPEN = 4, WCLOSE = 5, ADLY = 6;

  antitheft_ctrl_n dut (
    .clock(clock), .reset(reset), .one_hz_enable(one_hz_enable), .ignition(ignition),
    .door(door), .hidden_switch(hidden_switch), .brake(brake), .siren(siren),
    .status(status), .fuel_pump(fuel_pump), .state(state), .remaining(remaining)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      one_hz_enable = 1; tick(); one_hz_enable = 0;
    end
  endtask

  task automatic cmp(input string tag, input string fld, input logic [7:0] act, input int exp_v);
    if (exp_v >= 0) begin
      checks++;
      assert (act === 8'(exp_v)) else begin
        failures++;
        $error("FAIL %s.%s observed=%0d expected=%0d", tag, fld, act, exp_v);
      end
    end
  endtask

  task automatic pop_cmp();
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cmp(e.tag, "state", 8'(state), e.st);
      cmp(e.tag, "remaining", 8'(remaining), e.rem);
      cmp(e.tag, "siren", 8'(siren), e.sir);
      cmp(e.tag, "status", 8'(status), e.sts);
      cmp(e.tag, "fuel_pump", 8'(fuel_pump), e.fp);
    end
  endtask

  // One clock with the current inputs, optionally pulsing one_hz, then compare.
  task automatic step(input string tag, input bit hz, input int st, input int rem,
                      input int sir, input int sts, input int fp);
    exp_t e;
    e.tag = tag; e.st = st; e.rem = rem; e.sir = sir; e.sts = sts; e.fp = fp;
    exp_q.push_back(e);
    one_hz_enable = hz; tick(); one_hz_enable = 0;
    pop_cmp();
  endtask

  initial begin
    // Reset state
    reset = 1; tick(); tick();
    step("reset", 0, ARMED, 0, 0, 0, 0);
    reset = 0;
    step("armed_idle", 0, ARMED, 0, 0, 0, 0);
    step("armed_blink1", 1, ARMED, 0, 0, 1, 0);
    step("armed_blink2", 1, ARMED, 0, 0, 0, 0);

    // Passenger door entry delay then alarm
    door = 4'b0100;
    step("pass_trig", 0, TRIG, 15, 0, 1, 0);
    door = 4'b0000;
    step("trig_dec", 1, TRIG, 14, 0, 1, 0);
    pulses(13);
    step("trig_zero", 1, TRIG, 0, 0, 1, 0);
    step("alarm1", 0, ALRM, 10, 1, 1, 0);
    pulses(9);
    step("alarm_last", 1, ALRM, 0, 1, 1, 0);
    ignition = 1;
    step("alarm_exp_ign", 0, ARMED, 0, 0, 0, 0);
    step("armed_ign", 0, DISA, 0, 0, 0, 0);
    ignition = 0;
    step("to_wopen", 0, WOPEN, 0, 0, 0, 0);
    door = 4'b0001; step("wopen_drv", 0, WCLOSE, 0, 0, 0, 0);
    door = 4'b0000; step("wclose_shut", 0, ADLY, 6, 0, 0, 0);
    pulses(6);
    step("adly_armed", 0, ARMED, 0, 0, 0, 0);

    // Driver door wins, ignition disarms mid-countdown
    door = 4'b0011;
    step("drv_wins", 0, TRIG, 8, 0, 1, 0);
    door = 4'b0000;
    step("drv_dec", 1, TRIG, 7, 0, 1, 0);
    ignition = 1;
    step("trig_disarm", 0, DISA, 0, 0, 0, 0);

    // Immobiliser
    hidden_switch = 1; brake = 1;
    step("fuel_on", 0, DISA, 0, 0, 0, 1);
    hidden_switch = 0; brake = 0;
    step("fuel_hold", 0, DISA, 0, 0, 0, 1);
    ignition = 0;
    step("fuel_off", 0, WOPEN, 0, 0, 0, 0);

    // Disarm sequence with a door reopening during re-arm delay
    door = 4'b0001; step("seq_open", 0, WCLOSE, 0, 0, 0, 0);
    door = 4'b0000; step("seq_close", 0, ADLY, 6, 0, 0, 0);
    pulses(3);
    step("seq_rem2", 1, ADLY, 2, 0, 0, 0);
    door = 4'b1000; step("seq_reopen", 0, WCLOSE, 0, 0, 0, 0);
    door = 4'b0000; step("seq_reclose", 0, ADLY, 6, 0, 0, 0);
    pulses(5);
    step("seq_rem0", 1, ADLY, 0, 0, 0, 0);
    step("seq_armed", 0, ARMED, 0, 0, 0, 0);

    // Repeated alarms with a door held open: fourth alarm is silent
    door = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      step($sformatf("rep_trig%0d", i), 0, TRIG, 15, 0, 1, 0);
      pulses(15);
      step($sformatf("rep_alarm%0d", i), 0, ALRM, 10, (i < 3) ? 1 : 0, 1, 0);
      if (i < 3) begin
        pulses(10);
        step($sformatf("rep_rearm%0d", i), 0, ARMED, 0, 0, -1, 0);
      end
    end
    ignition = 1; door = 4'b0000;
    step("rep_disarm", 0, DISA, 0, 0, 0, 0);
    ignition = 0; tick(); door = 4'b0001; tick(); door = 4'b0000; tick();
    pulses(6); tick();
    door = 4'b0010;
    step("restore_trig", 0, TRIG, 15, 0, 1, 0);
    door = 4'b0000;
    pulses(15);
    step("restore_siren", 0, ALRM, 10, 1, 1, 0);

    // Reset during alarm and mid-countdown
    reset = 1; ignition = 1; door = 4'b1111;
    step("rst_alarm", 1, ARMED, 0, 0, 0, 0);
    reset = 0; ignition = 0; door = 4'b0100;
    step("rst_trig_pre", 0, TRIG, 15, 0, 1, 0);
    door = 4'b0000; pulses(4);
    reset = 1;
    step("rst_trig", 1, ARMED, 0, 0, 0, 0);
    reset = 0;
    step("post_rst", 0, ARMED, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
